// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute control sequencer driving every control line of the shared-bus datapath.
// Build macro CPU_SEQ_TRAP_EN: opcodes 0x8..0xF trap to HALTED and raise the sticky 'illegal' port.
module cpu_sequencer #(
    parameter int WIDTH      = 16,
    parameter int FETCH_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] instr,
    output logic             ram_out_ctrl,
    output logic             instr_ctrl,
    output logic             pc_enable,
    output logic             pcin,
    output logic             pc_out_ctrl,
    output logic [7:0]       rin,
    output logic [7:0]       rout,
    output logic             a_enable,
    output logic             acc_enable,
    output logic             addsub,
    output logic             xor_ctrl,
    output logic             acc_out_ctrl,
    output logic [WIDTH-1:0] cu_out,
    output logic             cu_out_ctrl,
    output logic             busy,
    output logic             done,
    output logic             halted
`ifdef CPU_SEQ_TRAP_EN
    ,
    output logic             illegal
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EX1,
        S_EX2,
        S_EX3,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MV   = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

    state_t     state_q, state_d;
    state_t     after_done;
    logic [3:0] wait_q, wait_d;
    logic [3:0] opcode;
    logic [7:0] rx_sel, ry_sel;

`ifdef CPU_SEQ_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q & rst;
`endif

    assign opcode = instr[15:12];
    assign rx_sel = 8'b1 << instr[11:9];
    assign ry_sel = 8'b1 << instr[8:6];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
`ifdef CPU_SEQ_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
`ifdef CPU_SEQ_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // NOTE: every output and next-state term gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
`ifdef CPU_SEQ_TRAP_EN
        illegal_d    = illegal_q;
`endif
        ram_out_ctrl = 1'b0;
        instr_ctrl   = 1'b0;
        pc_enable    = 1'b0;
        pcin         = 1'b0;
        pc_out_ctrl  = 1'b0;
        rin          = '0;
        rout         = '0;
        a_enable     = 1'b0;
        acc_enable   = 1'b0;
        addsub       = 1'b0;
        xor_ctrl     = 1'b0;
        acc_out_ctrl = 1'b0;
        cu_out       = '0;
        cu_out_ctrl  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        halted       = 1'b0;
        after_done   = run ? S_FETCH : S_IDLE;

        // Outputs stay quiet while reset is held so no write lands on the reset edge.
        if (rst) begin
            busy   = (state_q != S_IDLE) && (state_q != S_HALTED);
            halted = (state_q == S_HALTED);

            unique case (state_q)
                S_IDLE: begin
                    if (run) state_d = S_FETCH;
                end

                S_FETCH: begin
                    ram_out_ctrl = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        instr_ctrl = 1'b1;
                        pc_enable  = 1'b1;
                        wait_d     = '0;
                        state_d    = S_EX1;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end

                S_EX1: begin
                    done    = 1'b1;
                    state_d = after_done;
                    case (opcode)
                        OP_NOP: ;
                        OP_MV: begin
                            rout = ry_sel;
                            rin  = rx_sel;
                        end
                        OP_LDI: begin
                            cu_out      = WIDTH'(instr[8:0]);
                            cu_out_ctrl = 1'b1;
                            rin         = rx_sel;
                        end
                        OP_ADD, OP_SUB, OP_XOR: begin
                            done     = 1'b0;
                            rout     = rx_sel;
                            a_enable = 1'b1;
                            state_d  = S_EX2;
                        end
                        OP_JMP: begin
                            rout      = ry_sel;
                            pc_enable = 1'b1;
                            pcin      = 1'b1;
                        end
                        OP_HALT: state_d = S_HALTED;
                        default: begin
`ifdef CPU_SEQ_TRAP_EN
                            state_d   = S_HALTED;
                            illegal_d = 1'b1;
`endif
                        end
                    endcase
                end

                S_EX2: begin
                    rout       = ry_sel;
                    acc_enable = 1'b1;
                    addsub     = (opcode == OP_SUB);
                    xor_ctrl   = (opcode == OP_XOR);
                    state_d    = S_EX3;
                end

                S_EX3: begin
                    acc_out_ctrl = 1'b1;
                    rin          = rx_sel;
                    done         = 1'b1;
                    state_d      = after_done;
                end

                S_HALTED: ;

                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed per-cycle tables plus a randomized run against
// a micro-op expansion model. Instance 0 uses FETCH_WAIT = 0, instance 1 uses FETCH_WAIT = 3.
module tb_cpu_sequencer;

    typedef struct packed {
        logic       ram;
        logic       ictl;
        logic       pce;
        logic       pcin;
        logic       pco;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       a;
        logic       acc;
        logic       sub;
        logic       xr;
        logic       acco;
        logic [15:0] cu;
        logic       cuctl;
        logic       busy;
        logic       done;
        logic       halted;
    } ctl_t;

    typedef struct {
        ctl_t        e;
        logic        r;
        logic [15:0] w;
    } step_t;

`ifdef CPU_SEQ_TRAP_EN
    localparam bit TRAP = 1'b1;
    logic ill_v [2];
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_v   [2];
    logic        run_v   [2];
    logic [15:0] instr_v [2];
    ctl_t        obs     [2];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic ram, ictl, pce, pcin, pco, a, acc, sub, xr, acco, cuctl, busy, done, halted;
        logic [7:0]  rin, rout;
        logic [15:0] cu;

        cpu_sequencer #(.WIDTH(16), .FETCH_WAIT(g == 0 ? 0 : 3)) dut (
            .clk          (clk),
            .rst          (rst_v[g]),
            .run          (run_v[g]),
            .instr        (instr_v[g]),
            .ram_out_ctrl (ram),
            .instr_ctrl   (ictl),
            .pc_enable    (pce),
            .pcin         (pcin),
            .pc_out_ctrl  (pco),
            .rin          (rin),
            .rout         (rout),
            .a_enable     (a),
            .acc_enable   (acc),
            .addsub       (sub),
            .xor_ctrl     (xr),
            .acc_out_ctrl (acco),
            .cu_out       (cu),
            .cu_out_ctrl  (cuctl),
            .busy         (busy),
            .done         (done),
            .halted       (halted)
`ifdef CPU_SEQ_TRAP_EN
            ,
            .illegal      (ill_v[g])
`endif
        );

        assign obs[g] = '{ram: ram, ictl: ictl, pce: pce, pcin: pcin, pco: pco, rin: rin,
                          rout: rout, a: a, acc: acc, sub: sub, xr: xr, acco: acco, cu: cu,
                          cuctl: cuctl, busy: busy, done: done, halted: halted};
    end

    // One-bus-driver invariant, checked on every cycle of both instances.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_v[g] === 1'b1) begin
                int nd;
                nd = $countones({obs[g].ram, obs[g].pco, obs[g].acco, obs[g].cuctl, obs[g].rout});
                n_chk++;
                if (nd > 1) begin
                    n_fail++;
                    $display("FAIL bus_driver dut%0d t=%0t: %0d drivers, want at most 1", g, $time, nd);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int g);
        rst_v[g] = 1'b0;
        run_v[g] = 1'b0;
        adv();
        adv();
        rst_v[g] = 1'b1;
    endtask

    function automatic step_t st(input ctl_t e, input logic r, input logic [15:0] w);
        step_t s;
        s.e = e;
        s.r = r;
        s.w = w;
        return s;
    endfunction

    function automatic ctl_t c_fetch();
        ctl_t c = '0;
        c.busy = 1'b1; c.ram = 1'b1; c.ictl = 1'b1; c.pce = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_done();
        ctl_t c = '0;
        c.busy = 1'b1; c.done = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_halt();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    // ---------------- reference model for the randomized run ----------------
    ctl_t        mq [$];
    logic [15:0] m_prog [$];
    logic        m_halt;
    logic [3:0]  m_op;
    logic [15:0] m_next;

    function automatic logic [15:0] rand_word();
        logic [3:0] op;
        if (TRAP) op = 4'($urandom_range(0, 6));
        else begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h7) op = 4'h3;
        end
        return {op, 12'($urandom)};
    endfunction

    // Expands one instruction into its cycle-by-cycle control words, fetch included.
    function automatic void m_expand(input logic [15:0] w);
        ctl_t c;
        logic [7:0] rxs, rys;
        rxs = 8'b1 << w[11:9];
        rys = 8'b1 << w[8:6];
        mq.push_back(c_fetch());
        c = c_done();
        case (w[15:12])
            4'h1: begin c.rout = rys; c.rin = rxs; mq.push_back(c); end
            4'h2: begin c.cu = {7'b0, w[8:0]}; c.cuctl = 1'b1; c.rin = rxs; mq.push_back(c); end
            4'h3, 4'h4, 4'h5: begin
                c = '0; c.busy = 1'b1; c.rout = rxs; c.a = 1'b1; mq.push_back(c);
                c = '0; c.busy = 1'b1; c.rout = rys; c.acc = 1'b1;
                c.sub = (w[15:12] == 4'h4); c.xr = (w[15:12] == 4'h5); mq.push_back(c);
                c = c_done(); c.acco = 1'b1; c.rin = rxs; mq.push_back(c);
            end
            4'h6: begin c.rout = rys; c.pce = 1'b1; c.pcin = 1'b1; mq.push_back(c); end
            default: mq.push_back(c);
        endcase
    endfunction

    function automatic ctl_t m_expect();
        if (m_halt) return c_halt();
        if (mq.size() == 0) return '0;
        return mq[0];
    endfunction

    function automatic void m_advance(input logic run_now);
        logic fin;
        logic [15:0] w;
        if (m_halt) return;
        if (mq.size() != 0) begin
            fin = mq[0].done;
            void'(mq.pop_front());
            if (!fin) return;
            if (m_op == 4'h7 || (TRAP && m_op >= 4'h8)) begin
                m_halt = 1'b1;
                return;
            end
        end
        if (run_now) begin
            w = (m_prog.size() != 0) ? m_prog.pop_front() : rand_word();
            m_op   = w[15:12];
            m_next = w;
            m_expand(w);
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(0);
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                n_chk++;
                if (obs[g] !== ctl_t'('0)) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cycle %0d: got %h want 0", g, i, obs[g]);
                end
`ifdef CPU_SEQ_TRAP_EN
                n_chk++;
                if (ill_v[g] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_illegal dut%0d: got %b want 0", g, ill_v[g]);
                end
`endif
            end
            adv();
        end
    endtask

    task automatic test_ldi();
        step_t s [$];
        ctl_t  c;
        do_reset(0);
        c = c_done(); c.cu = 16'h00A5; c.cuctl = 1'b1; c.rin = 8'h01;
        s.push_back(st('0, 1'b1, 16'h20A5));
        s.push_back(st(c_fetch(), 1'b1, 16'h20A5));
        s.push_back(st(c, 1'b1, 16'h20A5));
        s.push_back(st(c_fetch(), 1'b0, 16'h20A5));
        s.push_back(st(c, 1'b0, 16'h20A5));
        s.push_back(st('0, 1'b0, 16'h20A5));
        foreach (s[i]) begin
            run_v[0] = s[i].r; instr_v[0] = s[i].w;
            @(negedge clk);
            n_chk++;
            if (obs[0] !== s[i].e) begin
                n_fail++;
                $display("FAIL ldi cycle %0d: got %h want %h", i, obs[0], s[i].e);
            end
            adv();
        end
    endtask

    task automatic test_sub();
        step_t s [$];
        ctl_t  c;
        do_reset(0);
        s.push_back(st('0, 1'b1, 16'h42C0));
        s.push_back(st(c_fetch(), 1'b1, 16'h42C0));
        c = '0; c.busy = 1'b1; c.rout = 8'h02; c.a = 1'b1;
        s.push_back(st(c, 1'b0, 16'h42C0));
        c = '0; c.busy = 1'b1; c.rout = 8'h08; c.acc = 1'b1; c.sub = 1'b1;
        s.push_back(st(c, 1'b0, 16'h42C0));
        c = c_done(); c.acco = 1'b1; c.rin = 8'h02;
        s.push_back(st(c, 1'b0, 16'h42C0));
        s.push_back(st('0, 1'b0, 16'h42C0));
        foreach (s[i]) begin
            run_v[0] = s[i].r; instr_v[0] = s[i].w;
            @(negedge clk);
            n_chk++;
            if (obs[0] !== s[i].e) begin
                n_fail++;
                $display("FAIL sub cycle %0d: got %h want %h", i, obs[0], s[i].e);
            end
            adv();
        end
    endtask

    // ADD r5,r5 (rx == ry) followed immediately by XOR r0,r1 with no idle bubble.
    task automatic test_back_to_back();
        step_t s [$];
        ctl_t  c;
        do_reset(0);
        s.push_back(st('0, 1'b1, 16'h3B40));
        s.push_back(st(c_fetch(), 1'b1, 16'h3B40));
        c = '0; c.busy = 1'b1; c.rout = 8'h20; c.a = 1'b1;
        s.push_back(st(c, 1'b1, 16'h3B40));
        c = '0; c.busy = 1'b1; c.rout = 8'h20; c.acc = 1'b1;
        s.push_back(st(c, 1'b1, 16'h3B40));
        c = c_done(); c.acco = 1'b1; c.rin = 8'h20;
        s.push_back(st(c, 1'b1, 16'h3B40));
        s.push_back(st(c_fetch(), 1'b1, 16'h5040));
        c = '0; c.busy = 1'b1; c.rout = 8'h01; c.a = 1'b1;
        s.push_back(st(c, 1'b0, 16'h5040));
        c = '0; c.busy = 1'b1; c.rout = 8'h02; c.acc = 1'b1; c.xr = 1'b1;
        s.push_back(st(c, 1'b0, 16'h5040));
        c = c_done(); c.acco = 1'b1; c.rin = 8'h01;
        s.push_back(st(c, 1'b0, 16'h5040));
        s.push_back(st('0, 1'b0, 16'h5040));
        foreach (s[i]) begin
            run_v[0] = s[i].r; instr_v[0] = s[i].w;
            @(negedge clk);
            n_chk++;
            if (obs[0] !== s[i].e) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", i, obs[0], s[i].e);
            end
            adv();
        end
    endtask

    task automatic test_jmp_halt();
        step_t s [$];
        ctl_t  c;
        do_reset(0);
        c = c_done(); c.rout = 8'h80; c.pce = 1'b1; c.pcin = 1'b1;
        s.push_back(st('0, 1'b1, 16'h61C0));
        s.push_back(st(c_fetch(), 1'b1, 16'h61C0));
        s.push_back(st(c, 1'b1, 16'h61C0));
        s.push_back(st(c_fetch(), 1'b1, 16'h7000));
        s.push_back(st(c_done(), 1'b1, 16'h7000));
        for (int k = 0; k < 20; k++) s.push_back(st(c_halt(), 1'b1, 16'h7000));
        foreach (s[i]) begin
            run_v[0] = s[i].r; instr_v[0] = s[i].w;
            @(negedge clk);
            n_chk++;
            if (obs[0] !== s[i].e) begin
                n_fail++;
                $display("FAIL jmp_halt cycle %0d: got %h want %h", i, obs[0], s[i].e);
            end
            adv();
        end
    endtask

    task automatic test_reset_mid_add();
        step_t s [$];
        ctl_t  c;
        do_reset(0);
        s.push_back(st('0, 1'b1, 16'h3540));
        s.push_back(st(c_fetch(), 1'b1, 16'h3540));
        c = '0; c.busy = 1'b1; c.rout = 8'h04; c.a = 1'b1;
        s.push_back(st(c, 1'b1, 16'h3540));
        c = '0; c.busy = 1'b1; c.rout = 8'h20; c.acc = 1'b1;
        s.push_back(st(c, 1'b1, 16'h3540));
        foreach (s[i]) begin
            run_v[0] = s[i].r; instr_v[0] = s[i].w;
            @(negedge clk);
            n_chk++;
            if (obs[0] !== s[i].e) begin
                n_fail++;
                $display("FAIL reset_mid_add cycle %0d: got %h want %h", i, obs[0], s[i].e);
            end
            if (i == 3) begin
                rst_v[0] = 1'b0;
                run_v[0] = 1'b0;
            end
            adv();
        end
        rst_v[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs[0] !== ctl_t'('0)) begin
                n_fail++;
                $display("FAIL reset_mid_add after cycle %0d: got %h want 0", i, obs[0]);
            end
            adv();
        end
    endtask

    task automatic test_fetch_wait();
        step_t s [$];
        ctl_t  cw;
        do_reset(1);
        cw = '0; cw.busy = 1'b1; cw.ram = 1'b1;
        s.push_back(st('0, 1'b1, 16'h0000));
        for (int k = 0; k < 3; k++) s.push_back(st(cw, 1'b1, 16'h0000));
        s.push_back(st(c_fetch(), 1'b1, 16'h0000));
        s.push_back(st(c_done(), 1'b1, 16'h0000));
        for (int k = 0; k < 3; k++) s.push_back(st(cw, 1'b1, 16'h0000));
        s.push_back(st(c_fetch(), 1'b0, 16'h0000));
        s.push_back(st(c_done(), 1'b0, 16'h0000));
        s.push_back(st('0, 1'b0, 16'h0000));
        foreach (s[i]) begin
            run_v[1] = s[i].r; instr_v[1] = s[i].w;
            @(negedge clk);
            n_chk++;
            if (obs[1] !== s[i].e) begin
                n_fail++;
                $display("FAIL fetch_wait cycle %0d: got %h want %h", i, obs[1], s[i].e);
            end
            adv();
        end
    endtask

    task automatic test_illegal();
        step_t s [$];
        do_reset(0);
        s.push_back(st('0, 1'b1, 16'hF000));
        s.push_back(st(c_fetch(), 1'b1, 16'hF000));
        s.push_back(st(c_done(), 1'b1, 16'hF000));
`ifdef CPU_SEQ_TRAP_EN
        for (int k = 0; k < 4; k++) s.push_back(st(c_halt(), 1'b1, 16'hF000));
`else
        s.push_back(st(c_fetch(), 1'b0, 16'hF000));
        s.push_back(st(c_done(), 1'b0, 16'hF000));
        s.push_back(st('0, 1'b0, 16'hF000));
`endif
        foreach (s[i]) begin
            run_v[0] = s[i].r; instr_v[0] = s[i].w;
            @(negedge clk);
            n_chk++;
            if (obs[0] !== s[i].e) begin
                n_fail++;
                $display("FAIL illegal cycle %0d: got %h want %h", i, obs[0], s[i].e);
            end
`ifdef CPU_SEQ_TRAP_EN
            n_chk++;
            if (ill_v[0] !== (i >= 3)) begin
                n_fail++;
                $display("FAIL illegal_flag cycle %0d: got %b want %b", i, ill_v[0], i >= 3);
            end
`endif
            adv();
        end
    endtask

    task automatic test_random();
        ctl_t e;
        logic rn;
        do_reset(0);
        mq.delete();
        m_prog.delete();
        m_halt = 1'b0;
        m_op   = 4'h0;
        m_next = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            rn = ($urandom_range(0, 7) != 0);
            run_v[0] = rn; instr_v[0] = m_next;
            @(negedge clk);
            e = m_expect();
            n_chk++;
            if (obs[0] !== e) begin
                n_fail++;
                $display("FAIL random cycle %0d instr %h: got %h want %h", i, m_next, obs[0], e);
            end
            m_advance(rn);
            adv();
        end
        m_prog.push_back(16'h7000);
        for (int i = 0; i < 40; i++) begin
            run_v[0] = 1'b1; instr_v[0] = m_next;
            @(negedge clk);
            e = m_expect();
            n_chk++;
            if (obs[0] !== e) begin
                n_fail++;
                $display("FAIL random_halt cycle %0d: got %h want %h", i, obs[0], e);
            end
            m_advance(1'b1);
            adv();
        end
        n_chk++;
        if (obs[0].halted !== 1'b1) begin
            n_fail++;
            $display("FAIL random_final_halted: got %b want 1", obs[0].halted);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_v[g]   = 1'b0;
            run_v[g]   = 1'b0;
            instr_v[g] = 16'h0000;
        end
        #1;
        test_reset();
        test_ldi();
        test_sub();
        test_back_to_back();
        test_jmp_halt();
        test_reset_mid_add();
        test_fetch_wait();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer that drives every control line of the 16-bit shared-bus datapath: register in/out enables, IR load, PC increment/load, ALU operand and operation selects, accumulator drive, RAM drive, and the constant (immediate) driver.
- Consumes the instruction register contents and issues one fetch/execute sequence per instruction.
- Guarantees at most one bus driver per cycle.

Parameters:
- WIDTH, 16, data/bus width; cu_out width.
- FETCH_WAIT, 0, extra RAM wait cycles inserted before the IR captures in FETCH (0..15).

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous active-low reset.
- run  in  1  level; sequencer fetches while high.
- instr  in  WIDTH  instruction register output. Fields: [15:12] opcode, [11:9] rx, [8:6] ry, [8:0] imm9.
- ram_out_ctrl  out  1  RAM drives bus.
- instr_ctrl  out  1  IR loads from bus.
- pc_enable  out  1  PC update.
- pcin  out  1  0 = PC increment, 1 = PC load from bus.
- pc_out_ctrl  out  1  PC drives bus (reserved, always 0 in this ISA).
- rin  out  8  register load enables, bit i = register i.
- rout  out  8  register bus-drive enables, one-hot or zero.
- a_enable  out  1  ALU operand A loads from bus.
- acc_enable  out  1  accumulator captures ALU result.
- addsub  out  1  0 = add, 1 = subtract.
- xor_ctrl  out  1  1 = XOR overrides add/sub.
- acc_out_ctrl  out  1  accumulator drives bus.
- cu_out  out  WIDTH  immediate value for the bus.
- cu_out_ctrl  out  1  cu_out drives bus.
- busy  out  1  high in any state except IDLE and HALTED.
- done  out  1  one-cycle pulse on the last cycle of each instruction.
- halted  out  1  high in HALTED.

Behaviour:
- Reset (rst == 0 at an edge):
  - Next state is IDLE.
  - All outputs are 0, including cu_out = 0.
  - The wait counter clears.
  - Reset wins over any in-flight instruction; no partial write completes after the reset edge.
- Default output value is 0 in every state unless listed below.
- IDLE: if run = 1, go to FETCH; otherwise stay in IDLE.
- FETCH:
  - Wait counter counts FETCH_WAIT cycles with ram_out_ctrl = 1 only.
  - Final FETCH cycle asserts ram_out_ctrl, instr_ctrl and pc_enable (pcin = 0), then goes to EX1.
  - FETCH_WAIT = 0 makes FETCH a single cycle.
- Execute states decode instr, which is valid from EX1 onward:
  - 0x0 NOP: EX1 asserts done only.
  - 0x1 MV: EX1 asserts rout[ry], rin[rx] and done.
  - 0x2 LDI: EX1 sets cu_out = zero-extended imm9 and asserts cu_out_ctrl, rin[rx] and done.
  - 0x3 ADD / 0x4 SUB / 0x5 XOR:
    - EX1: rout[rx], a_enable.
    - EX2: rout[ry], acc_enable; addsub = 1 for SUB; xor_ctrl = 1 for XOR.
    - EX3: acc_out_ctrl, rin[rx], done.
    - Result wraps modulo 2^WIDTH; no flags.
  - 0x6 JMP: EX1 asserts rout[ry], pc_enable, pcin = 1 and done.
  - 0x7 HALT: EX1 asserts done and goes to HALTED. HALTED is left only by reset; run is ignored there.
  - 0x8..0xF: handled per TRAP_EN.
- After any done cycle other than HALT:
  - next state is FETCH if run = 1, else IDLE;
  - no idle bubble between instructions.
- Dropping run mid-instruction does not abort; the instruction completes.
- rx == ry is legal: MV is a no-op write, and ADD rx,rx doubles rx.
- Invariant: in every cycle at most one of ram_out_ctrl, pc_out_ctrl, acc_out_ctrl, cu_out_ctrl or any rout bit is high.
- Latency from the start of FETCH (FETCH_WAIT = 0): NOP/MV/LDI/JMP/HALT take 2 cycles; ADD/SUB/XOR take 4.

Optional Feature:
- Macro: CPU_SEQ_TRAP_EN.
- Defined: opcodes 0x8..0xF assert done in EX1 and go to HALTED. An extra output port, illegal (1 bit), goes high and stays high until reset.
- Undefined: opcodes 0x8..0xF execute as NOP. The illegal port does not exist.

Test Plan:
- Reset mid-ADD: assert rst = 0 during EX2, release. Next cycle all outputs are 0 and state is IDLE; with run = 0 no bus driver is ever asserted.
- LDI: instr = 0x2_0A5 (rx = 0, imm9 = 0x0A5), run = 1. EX1 shows cu_out = 0x00A5, cu_out_ctrl = 1, rin = 0x01, done = 1; the next cycle is FETCH.
- SUB: instr = 0x4_2C0 (rx = 1, ry = 3), run = 1, FETCH_WAIT = 0.
  - EX1: rout = 0x02 with a_enable.
  - EX2: rout = 0x08, acc_enable, addsub = 1.
  - EX3: acc_out_ctrl, rin = 0x02, done.
  - done occurs exactly 4 cycles after FETCH entry.
- JMP then HALT: 0x6_1C0 asserts rout = 0x80, pc_enable, pcin = 1. A following 0x7000 sets halted = 1, and busy stays 0 for 20 cycles with run = 1.
- FETCH_WAIT = 3: ram_out_ctrl is high for 4 consecutive cycles, and instr_ctrl/pc_enable are high only on the 4th.
- Illegal 0xF000:
  - CPU_SEQ_TRAP_EN defined: halted = 1 and illegal = 1.
  - Undefined: behaves as NOP and fetches again.
- Throughout all tests, check the one-bus-driver invariant every cycle.
